// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, duty type and counter direction for the PWM path.
// Used by pwm_gen, the nonoverlap stage and the duty-computation block.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 11;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    localparam duty_t PWM_MAX = '1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_period_cnt.sv
// pwm_period_cnt: period counter with boundary (duty load) and start detect.
// PWM_CENTER_ALIGNED_EN selects the up/down counter; default is sawtooth.
module pwm_period_cnt
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             start
);

    localparam logic [WIDTH-1:0] TOP = '1;

`ifdef PWM_CENTER_ALIGNED_EN

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dir_e dir;

    // Triangle: up 0..TOP, down to 1, repeat; parked at 0 going up when idle
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt == TOP) begin
                cnt <= cnt - 1'b1;
                dir <= DIR_DOWN;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            if (cnt == ONE) begin
                dir <= DIR_UP;
            end
            cnt <= cnt - 1'b1;
        end
    end

    assign wrap  = (dir == DIR_UP) && (cnt == TOP);
    assign start = (cnt == TOP);

`else

    // Sawtooth: free-running wrap from TOP to 0, held at 0 when idle
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wrap  = (cnt == TOP);
    assign start = (cnt == '0);

`endif

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: complementary PWM pair with boundary-synchronous duty update.
// Define PWM_CENTER_ALIGNED_EN for centre-aligned (up/down) operation.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_wr,
    output logic             duty_pend,
    output logic             pwm_high,
    output logic             pwm_low,
    output logic             pwm_synch
);

    logic [WIDTH-1:0] cnt;
    logic             wrap;
    logic             start;
    logic [WIDTH-1:0] duty_buf;
    logic [WIDTH-1:0] duty_act;
    logic             load;
    logic             on;

    pwm_period_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .cnt   (cnt),
        .wrap  (wrap),
        .start (start)
    );

    // Idle cycles also count as a boundary so a restart uses the newest duty
    assign load = !en || wrap;
    assign on   = (cnt < duty_act);

    // Double buffer: a write on the boundary bypasses straight to duty_act
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_buf  <= '0;
            duty_act  <= '0;
            duty_pend <= 1'b0;
        end else if (load) begin
            if (duty_wr) begin
                duty_buf <= duty;
                duty_act <= duty;
            end else if (duty_pend) begin
                duty_act <= duty_buf;
            end
            duty_pend <= 1'b0;
        end else if (duty_wr) begin
            duty_buf  <= duty;
            duty_pend <= 1'b1;
        end
    end

    // Registered drive requests; high and low are exclusive by construction
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_high  <= 1'b0;
            pwm_low   <= 1'b0;
            pwm_synch <= 1'b0;
        end else begin
            pwm_high  <= en && on;
            pwm_low   <= en && !on;
            pwm_synch <= en && start;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scenario tasks plus a per-cycle reference model of the
// edge-aligned PWM (period position, latest written duty, applied duty).
module tb_pwm_gen;

    localparam int W = 11;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] duty = '0;
    logic         duty_wr = 1'b0;
    logic         duty_pend;
    logic         pwm_high;
    logic         pwm_low;
    logic         pwm_synch;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    int m_phase = 0;
    int m_act = 0;
    int m_latest = 0;
    bit m_pend = 1'b0;
    bit e_high = 1'b0;
    bit e_low = 1'b0;
    bit e_synch = 1'b0;

    pwm_gen #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .duty      (duty),
        .duty_wr   (duty_wr),
        .duty_pend (duty_pend),
        .pwm_high  (pwm_high),
        .pwm_low   (pwm_low),
        .pwm_synch (pwm_synch)
    );

    always #5 clk = ~clk;

    // Reference: position in period, newest written duty, duty in force
    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_act    <= 0;
            m_latest <= 0;
            m_pend   <= 1'b0;
            e_high   <= 1'b0;
            e_low    <= 1'b0;
            e_synch  <= 1'b0;
        end else begin
            e_high  <= en && (m_phase < m_act);
            e_low   <= en && !(m_phase < m_act);
            e_synch <= en && (m_phase == 0);
            if (!en || m_phase == N - 1) begin
                if (duty_wr) m_act <= int'(duty);
                else if (m_pend) m_act <= m_latest;
                m_pend <= 1'b0;
            end else if (duty_wr) begin
                m_pend <= 1'b1;
            end
            if (duty_wr) m_latest <= int'(duty);
            m_phase <= en ? (m_phase + 1) % N : 0;
        end
    end

    // Every cycle: outputs must follow the reference model
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ({pwm_high, pwm_low, pwm_synch, duty_pend} !==
                {e_high, e_low, e_synch, m_pend}) begin
                failures++;
                $display("FAIL cycle t=%0t h/l/s/p got %b%b%b%b want %b%b%b%b",
                         $time, pwm_high, pwm_low, pwm_synch, duty_pend,
                         e_high, e_low, e_synch, m_pend);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 5000; i++) begin
            cyc();
            if (m_phase == p) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_phase %0d timed out, phase got %0d", p, m_phase);
    endtask

    task automatic wait_synch();
        for (int i = 0; i < 5000; i++) begin
            cyc();
            if (pwm_synch === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_synch timed out, synch got 0 want 1");
    endtask

    task automatic measure(output int hi, output int lo, output int sy,
                           output int ov, output int pd);
        hi = 0; lo = 0; sy = 0; ov = 0; pd = 0;
        for (int i = 0; i < N; i++) begin
            hi += int'(pwm_high);
            lo += int'(pwm_low);
            sy += int'(pwm_synch);
            ov += int'(pwm_high & pwm_low);
            pd += int'(duty_pend);
            cyc();
        end
    endtask

    task automatic write_duty(input int v);
        duty = W'(v);
        duty_wr = 1'b1;
        cyc();
        duty_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        duty_wr = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({pwm_high, pwm_low, pwm_synch, duty_pend} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b%b%b%b want 0000",
                     pwm_high, pwm_low, pwm_synch, duty_pend);
        end
        mon_on = 1'b1;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int hi, lo, sy, ov, pd;
        write_duty(32'h200);
        en = 1'b1;
        wait_synch();
        for (int p = 0; p < 2; p++) begin
            measure(hi, lo, sy, ov, pd);
            checks++;
            if (hi !== 512 || lo !== 1536) begin
                failures++;
                $display("FAIL basic_hi_lo got %0d/%0d want 512/1536", hi, lo);
            end
            checks++;
            if (sy !== 1 || ov !== 0) begin
                failures++;
                $display("FAIL basic_synch_ovl got %0d/%0d want 1/0", sy, ov);
            end
        end
    endtask

    task automatic test_pending_update();
        int hi, lo, sy, ov, pd;
        hi = 0; pd = 0;
        for (int i = 0; i < N; i++) begin
            duty_wr = 1'b0;
            if (m_phase == 100) begin
                duty = W'(32'h600);
                duty_wr = 1'b1;
            end
            hi += int'(pwm_high);
            pd += int'(duty_pend);
            cyc();
        end
        duty_wr = 1'b0;
        checks++;
        if (hi !== 512) begin
            failures++;
            $display("FAIL pend_cur_period hi got %0d want 512", hi);
        end
        checks++;
        if (pd !== 1947) begin
            failures++;
            $display("FAIL pend_cycles got %0d want 1947", pd);
        end
        measure(hi, lo, sy, ov, pd);
        checks++;
        if (hi !== 1536 || pd !== 0) begin
            failures++;
            $display("FAIL pend_next hi/pend got %0d/%0d want 1536/0", hi, pd);
        end
    endtask

    task automatic test_boundary_write();
        int hi, lo, sy, ov, pd, d;
        d = int'($urandom_range(1, N - 2));
        wait_phase(N - 1);
        write_duty(d);
        checks++;
        if (duty_pend !== 1'b0) begin
            failures++;
            $display("FAIL boundary_pend got %b want 0", duty_pend);
        end
        wait_synch();
        measure(hi, lo, sy, ov, pd);
        checks++;
        if (hi !== d || pd !== 0) begin
            failures++;
            $display("FAIL boundary_apply hi/pend got %0d/%0d want %0d/0",
                     hi, pd, d);
        end
    endtask

    task automatic test_back_to_back(output int b);
        int hi, lo, sy, ov, pd, a;
        a = int'($urandom_range(200, 1800));
        b = int'($urandom_range(200, 1800));
        wait_phase(50);
        write_duty(a);
        wait_phase(60);
        write_duty(b);
        wait_synch();
        measure(hi, lo, sy, ov, pd);
        checks++;
        if (hi !== b) begin
            failures++;
            $display("FAIL back_to_back hi got %0d want %0d (first %0d)",
                     hi, b, a);
        end
    endtask

    task automatic test_en_drop(input int act);
        int hi, lo, sy, ov, pd;
        wait_phase(300);
        en = 1'b0;
        cyc();
        checks++;
        if ({pwm_high, pwm_low, pwm_synch} !== 3'b000) begin
            failures++;
            $display("FAIL en_drop_out got %b%b%b want 000",
                     pwm_high, pwm_low, pwm_synch);
        end
        repeat (7) cyc();
        en = 1'b1;
        cyc();
        checks++;
        if (pwm_synch !== 1'b1 || pwm_high !== 1'b1) begin
            failures++;
            $display("FAIL en_restart synch/high got %b/%b want 1/1",
                     pwm_synch, pwm_high);
        end
        measure(hi, lo, sy, ov, pd);
        checks++;
        if (hi !== act || sy !== 1) begin
            failures++;
            $display("FAIL en_restart_period hi/synch got %0d/%0d want %0d/1",
                     hi, sy, act);
        end
    endtask

    task automatic test_reset_mid();
        int hi;
        wait_phase(20);
        write_duty(int'($urandom_range(1, N - 1)));
        rst = 1'b1;
        cyc();
        checks++;
        if ({pwm_high, pwm_low, pwm_synch, duty_pend} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got %b%b%b%b want 0000",
                     pwm_high, pwm_low, pwm_synch, duty_pend);
        end
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < N + 50; i++) begin
            hi += int'(pwm_high);
            cyc();
        end
        checks++;
        if (hi !== 0) begin
            failures++;
            $display("FAIL reset_mid_after hi got %0d want 0", hi);
        end
    endtask

    task automatic test_extreme(input int d, input int want_hi);
        int hi, lo, sy, ov, pd;
        do_reset();
        write_duty(d);
        en = 1'b1;
        wait_synch();
        measure(hi, lo, sy, ov, pd);
        checks++;
        if (hi !== want_hi || lo !== N - want_hi || ov !== 0) begin
            failures++;
            $display("FAIL extreme_%0d hi/lo/ovl got %0d/%0d/%0d want %0d/%0d/0",
                     d, hi, lo, ov, want_hi, N - want_hi);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20000; i++) begin
            duty_wr = ($urandom_range(0, 299) == 0);
            duty = W'($urandom);
            if ($urandom_range(0, 1999) == 0) en = !en;
            cyc();
        end
        duty_wr = 1'b0;
    endtask

    initial begin
        int b;
        test_reset();
        test_basic();
        test_pending_update();
        test_boundary_write();
        test_back_to_back(b);
        test_en_drop(b);
        test_reset_mid();
        test_extreme(0, 0);
        test_extreme(N - 1, N - 1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
